sim_cycle_controller: RTL and testbench

// - Parametrised simulation-cycle sequencer: runs a bounded number of simulated cycles.
// - Each simulated cycle is NUM_PHASES clock-phases long; adds pause / single-step / abort control.
// - Adds a runtime max_cycle bound.
// - Sits at the top of the simulator; phase/cycle_done drive the router and link update stages.

---
 rtl/sim_cycle_controller.sv | 158 +++++++++++++++
 tb/tb_sim_cycle_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sim_cycle_controller.sv
// Simulation-cycle sequencer: runs max_cycle simulated cycles of NUM_PHASES clocks each, with pause/step/abort.
// Optional stall_cycles counter is built when SIM_STALL_CNT_EN is defined.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | executing phases
//   PAUSE | halted on a cycle boundary
//   DONE  | run complete, current_cycle == max latch
module sim_cycle_controller #(
  parameter int CYCLE_WIDTH = 5,
  parameter int NUM_PHASES  = 2,
  localparam int PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   resume,
  input  logic                   step,
  input  logic                   abort,
  input  logic [CYCLE_WIDTH-1:0] max_cycle,
  output logic [1:0]             state,
  output logic [CYCLE_WIDTH-1:0] current_cycle,
  output logic [PHASE_W-1:0]     phase,
  output logic                   phase_valid,
  output logic                   cycle_done,
  output logic                   done
`ifdef SIM_STALL_CNT_EN
  ,
  output logic [CYCLE_WIDTH+3:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [PHASE_W-1:0]     LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE  = CYCLE_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [CYCLE_WIDTH-1:0]   cycle_q, cycle_d;
  logic [CYCLE_WIDTH-1:0]   max_q, max_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic                     pend_pause_q, pend_pause_d;
  logic                     stepping_q, stepping_d;
  logic [CYCLE_WIDTH-1:0]   cycle_inc;
  logic                     start_acc;

  // Saturating increment; a run never goes past max latch anyway.
  assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CYCLE_ONE;
  assign start_acc = !abort && start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cycle_q      <= '0;
      max_q        <= '0;
      phase_q      <= '0;
      pend_pause_q <= 1'b0;
      stepping_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      max_q        <= max_d;
      phase_q      <= phase_d;
      pend_pause_q <= pend_pause_d;
      stepping_q   <= stepping_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    max_d        = max_q;
    phase_d      = phase_q;
    pend_pause_d = pend_pause_q;
    stepping_d   = stepping_q;
    if (abort) begin
      state_d      = S_IDLE;
      phase_d      = '0;
      pend_pause_d = 1'b0;
      stepping_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            max_d        = max_cycle;
            cycle_d      = '0;
            phase_d      = '0;
            pend_pause_d = 1'b0;
            stepping_d   = 1'b0;
            state_d      = (max_cycle == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (phase_q != LAST_PHASE) begin
            phase_d      = phase_q + PHASE_W'(1);
            pend_pause_d = pend_pause_q | pause;
          end else begin
            // A pause arriving on the boundary clock takes effect at this boundary.
            phase_d      = '0;
            cycle_d      = cycle_inc;
            pend_pause_d = 1'b0;
            stepping_d   = 1'b0;
            if (cycle_inc == max_q)
              state_d = S_DONE;
            else if (pend_pause_q || pause || stepping_q)
              state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (resume) begin
            state_d = S_RUN;
          end else if (step) begin
            state_d    = S_RUN;
            stepping_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state         = state_q;
    current_cycle = cycle_q;
    phase         = phase_q;
    phase_valid   = (state_q == S_RUN);
    cycle_done    = (state_q == S_RUN) && (phase_q == LAST_PHASE);
    done          = (state_q == S_DONE);
  end

`ifdef SIM_STALL_CNT_EN
  logic [CYCLE_WIDTH+3:0] stall_q, stall_d;

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  always_comb begin
    stall_d = stall_q;
    if (start_acc)
      stall_d = '0;
    else if ((state_q == S_PAUSE) && (stall_q != '1))
      stall_d = stall_q + (CYCLE_WIDTH + 4)'(1);
  end

  assign stall_cycles = stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_sim_cycle_controller.sv
// Bench for sim_cycle_controller: directed scenarios then random stimulus against a behavioural model.
module tb_sim_cycle_controller;
  localparam int CW = 5;
  localparam int NP = 2;
  localparam int PW = 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam int STALL_MAX = (1 << (CW + 4)) - 1;

  logic clk = 1'b0;
  logic reset, start, pause, resume, step, abort;
  logic [CW-1:0] max_cycle;
  logic [1:0] state;
  logic [CW-1:0] current_cycle;
  logic [PW-1:0] phase;
  logic phase_valid, cycle_done, done;
`ifdef SIM_STALL_CNT_EN
  logic [CW+3:0] stall_cycles;
`endif

  sim_cycle_controller #(.CYCLE_WIDTH(CW), .NUM_PHASES(NP)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .resume(resume),
    .step(step), .abort(abort), .max_cycle(max_cycle), .state(state),
    .current_cycle(current_cycle), .phase(phase), .phase_valid(phase_valid),
    .cycle_done(cycle_done), .done(done)
`ifdef SIM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_state, m_cycle, m_phase, m_pend, m_stepping, m_max, m_stall;
  int cd_cnt, pv_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, s, p, re, st, ab, input int mc);
    int ns, nc, np, npend, nstep, nmax, nstall;
    ns = m_state; nc = m_cycle; np = m_phase; npend = m_pend;
    nstep = m_stepping; nmax = m_max; nstall = m_stall;
    if (r) begin
      ns = M_IDLE; nc = 0; np = 0; npend = 0; nstep = 0; nmax = 0; nstall = 0;
    end else begin
      if (m_state == M_PAUSE && m_stall < STALL_MAX) nstall = m_stall + 1;
      if (ab) begin
        ns = M_IDLE; np = 0; npend = 0; nstep = 0;
      end else if (m_state == M_IDLE || m_state == M_DONE) begin
        if (s) begin
          nmax = mc; nc = 0; np = 0; npend = 0; nstep = 0; nstall = 0;
          ns = (mc == 0) ? M_DONE : M_RUN;
        end
      end else if (m_state == M_RUN) begin
        if (m_phase < NP - 1) begin
          np = m_phase + 1;
          if (p) npend = 1;
        end else begin
          np = 0;
          nc = (m_cycle < (1 << CW) - 1) ? m_cycle + 1 : m_cycle;
          npend = 0; nstep = 0;
          if (nc == m_max) ns = M_DONE;
          else if (m_pend != 0 || p || m_stepping != 0) ns = M_PAUSE;
        end
      end else begin
        if (re) ns = M_RUN;
        else if (st) begin ns = M_RUN; nstep = 1; end
      end
    end
    m_state = ns; m_cycle = nc; m_phase = np; m_pend = npend;
    m_stepping = nstep; m_max = nmax; m_stall = nstall;
  endtask

  task automatic check_all();
    chk("state", int'(state), m_state);
    chk("current_cycle", int'(current_cycle), m_cycle);
    chk("phase", int'(phase), m_phase);
    chk("phase_valid", int'(phase_valid), (m_state == M_RUN) ? 1 : 0);
    chk("cycle_done", int'(cycle_done), (m_state == M_RUN && m_phase == NP - 1) ? 1 : 0);
    chk("done", int'(done), (m_state == M_DONE) ? 1 : 0);
`ifdef SIM_STALL_CNT_EN
    chk("stall_cycles", int'(stall_cycles), m_stall);
`endif
    if (cycle_done) cd_cnt++;
    if (phase_valid) pv_cnt++;
  endtask

  task automatic tick(input bit r, s, p, re, st, ab, input int mc);
    reset = r; start = s; pause = p; resume = re; step = st; abort = ab;
    max_cycle = CW'(mc);
    @(posedge clk);
    model_step(r, s, p, re, st, ab, mc);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; start = 0; pause = 0; resume = 0; step = 0; abort = 0; max_cycle = '0;
    m_state = 0; m_cycle = 0; m_phase = 0; m_pend = 0; m_stepping = 0; m_max = 0; m_stall = 0;
    cd_cnt = 0; pv_cnt = 0;
    #1;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0, 7);
    chk("reset_state", int'(state), 0);
    chk("reset_cycle", int'(current_cycle), 0);

    // max_cycle=3: 6 RUN clocks, 3 cycle_done pulses
    cd_cnt = 0; pv_cnt = 0;
    tick(0, 1, 0, 0, 0, 0, 3);
    idle(6);
    chk("run3_cd_pulses", cd_cnt, 3);
    chk("run3_run_clocks", pv_cnt, 6);
    chk("run3_done_state", int'(state), M_DONE);
    chk("run3_cycle", int'(current_cycle), 3);
    idle(2);

    // pause mid-cycle, then single step, then resume+step together
    tick(0, 1, 0, 0, 0, 0, 5);
    idle(2);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("pause_cycle", int'(current_cycle), 2);
    chk("pause_state", int'(state), M_PAUSE);
    tick(0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("step_cycle", int'(current_cycle), 3);
    chk("step_state", int'(state), M_PAUSE);
    tick(0, 0, 0, 1, 1, 0, 0);
    idle(3);
    chk("resume_wins_state", int'(state), M_RUN);
    idle(2);
    chk("after_resume_done", int'(state), M_DONE);

    // abort + pause at cycle 2 phase 1
    tick(0, 1, 0, 0, 0, 0, 5);
    idle(5);
    tick(0, 0, 1, 0, 0, 1, 0);
    chk("abort_state", int'(state), M_IDLE);
    chk("abort_phase", int'(phase), 0);
    chk("abort_cycle", int'(current_cycle), 2);
    tick(0, 1, 0, 0, 0, 1, 4);
    chk("abort_over_start", int'(state), M_IDLE);

    // max_cycle=31: saturate at 31, no wrap
    pv_cnt = 0;
    tick(0, 1, 0, 0, 0, 0, 31);
    idle(62);
    chk("max31_run_clocks", pv_cnt, 62);
    chk("max31_state", int'(state), M_DONE);
    chk("max31_cycle", int'(current_cycle), 31);
    idle(3);
    chk("max31_hold", int'(current_cycle), 31);
    tick(0, 1, 0, 0, 0, 0, 4);
    chk("restart_cycle", int'(current_cycle), 0);
    idle(9);

    // max_cycle=0: straight to DONE
    pv_cnt = 0; cd_cnt = 0;
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("max0_state", int'(state), M_DONE);
    idle(4);
    chk("max0_pv", pv_cnt, 0);
    chk("max0_cd", cd_cnt, 0);

    // PAUSE held 10 clocks
    tick(0, 1, 0, 0, 0, 0, 6);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("stall_enter_pause", int'(state), M_PAUSE);
    idle(9);
    tick(0, 0, 0, 1, 0, 0, 0);
`ifdef SIM_STALL_CNT_EN
    chk("stall_10", int'(stall_cycles), 10);
`endif
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0, 0, 6);
`ifdef SIM_STALL_CNT_EN
    chk("stall_cleared", int'(stall_cycles), 0);
`endif

    // random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      bit r, s, p, re, st, ab;
      int mc;
      r  = ($urandom_range(0, 99) == 0);
      ab = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 7) == 0);
      mc = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 8));
      tick(r, s, p, re, st, ab, mc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
